// File: rtl/sw_debounce_multi.sv
// Multi-channel switch debouncer: each channel has its own synchroniser, stability counter,
// debounced level, edge pulses and optional push-on/push-off toggle state.
module sw_debounce_multi #(
    parameter int                NUM_CH      = 9,
    parameter int                STABLE_CNT  = 15,
    parameter logic [NUM_CH-1:0] RESET_VAL   = '0,
    parameter logic [NUM_CH-1:0] TOGGLE_MASK = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] in,
    input  logic              tgl_clr,
    output logic [NUM_CH-1:0] out,
    output logic [NUM_CH-1:0] level,
    output logic [NUM_CH-1:0] rise,
    output logic [NUM_CH-1:0] fall,
    output logic              any_change
);

    localparam int CNT_W = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT - 1);

    logic [NUM_CH-1:0] db;
    logic [NUM_CH-1:0] tgl;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic             s1;
        logic             s2;
        logic             db_r;
        logic             rise_r;
        logic             fall_r;
        logic             tgl_r;
        logic [CNT_W-1:0] cnt;

        // Any sample matching the current level restarts qualification from zero.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                s1     <= RESET_VAL[i];
                s2     <= RESET_VAL[i];
                db_r   <= RESET_VAL[i];
                cnt    <= '0;
                rise_r <= 1'b0;
                fall_r <= 1'b0;
                tgl_r  <= 1'b0;
            end else begin
                s1     <= in[i];
                s2     <= s1;
                rise_r <= 1'b0;
                fall_r <= 1'b0;
                if (s2 == db_r) begin
                    cnt <= '0;
                end else if (cnt == CNT_MAX) begin
                    db_r   <= s2;
                    cnt    <= '0;
                    rise_r <= s2;
                    fall_r <= ~s2;
                    if (TOGGLE_MASK[i] && s2)
                        tgl_r <= ~tgl_r;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
                if (tgl_clr)
                    tgl_r <= 1'b0;
            end
        end

        assign db[i]   = db_r;
        assign tgl[i]  = tgl_r;
        assign rise[i] = rise_r;
        assign fall[i] = fall_r;
    end

    assign level      = db;
    assign out        = (TOGGLE_MASK & tgl) | (~TOGGLE_MASK & db);
    assign any_change = |{rise, fall};

endmodule

// File: tb/tb_sw_debounce_multi.sv
// Directed bench for sw_debounce_multi: expected edge events are queued by the stimulus
// and matched by a monitor whenever the DUT reports a change.
module tb_sw_debounce_multi;

    localparam int         NCH = 4;
    localparam int         SC  = 4;
    localparam int         LAT = SC + 2;
    localparam logic [3:0] RV  = 4'b0000;
    localparam logic [3:0] TM  = 4'b1000;

    logic           clock   = 1'b0;
    logic           reset_n = 1'b0;
    logic           tgl_clr = 1'b0;
    logic [NCH-1:0] in      = '0;
    logic [NCH-1:0] out;
    logic [NCH-1:0] level;
    logic [NCH-1:0] rise;
    logic [NCH-1:0] fall;
    logic           any_change;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] out;
        logic [3:0] level;
        string      name;
    } ev_t;

    ev_t sbq[$];

    sw_debounce_multi #(
        .NUM_CH(NCH),
        .STABLE_CNT(SC),
        .RESET_VAL(RV),
        .TOGGLE_MASK(TM)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .in(in),
        .tgl_clr(tgl_clr),
        .out(out),
        .level(level),
        .rise(rise),
        .fall(fall),
        .any_change(any_change)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic applyStimulus(input logic [3:0] v);
        in = v;
    endtask

    task automatic expectEvent(input string name, input int delay, input logic [3:0] r,
                               input logic [3:0] f, input logic [3:0] o, input logic [3:0] l);
        ev_t e;
        e.cyc   = cyc + delay;
        e.rise  = r;
        e.fall  = f;
        e.out   = o;
        e.level = l;
        e.name  = name;
        sbq.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [3:0] o, input logic [3:0] l,
                               input logic [3:0] r, input logic [3:0] f, input logic a);
        checks++;
        if ({out, level, rise, fall, any_change} !== {o, l, r, f, a}) begin
            errors++;
            $display("[TB] FAIL %s: got out=%b level=%b rise=%b fall=%b any=%b, want out=%b level=%b rise=%b fall=%b any=%b",
                     name, out, level, rise, fall, any_change, o, l, r, f, a);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Every reported change must match the oldest outstanding expectation, including its cycle.
    always @(negedge clock) begin : monitor
        ev_t e;
        if (reset_n && any_change) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_event: cycle=%0d rise=%b fall=%b out=%b level=%b, want no event",
                         cyc, rise, fall, out, level);
            end else begin
                e = sbq.pop_front();
                if (cyc !== e.cyc || rise !== e.rise || fall !== e.fall || out !== e.out || level !== e.level) begin
                    errors++;
                    $display("[TB] FAIL %s: cycle=%0d rise=%b fall=%b out=%b level=%b, want cycle=%0d rise=%b fall=%b out=%b level=%b",
                             e.name, cyc, rise, fall, out, level, e.cyc, e.rise, e.fall, e.out, e.level);
                end
            end
        end
    end

    initial begin
        logic [3:0] tglExp;

        reset_n = 1'b0;
        applyStimulus(4'b1111);
        #2;
        checkOutput("reset_immediate", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        step(2);
        checkOutput("reset_held", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

        reset_n = 1'b1;
        expectEvent("release_rise", LAT, 4'b1111, 4'b0000, 4'b1111, 4'b1111);
        step(LAT + 3);
        checkOutput("release_settled", 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0);

        applyStimulus(4'b0000);
        expectEvent("all_fall", LAT, 4'b0000, 4'b1111, 4'b1000, 4'b0000);
        step(LAT + 3);
        checkOutput("toggle_kept_after_fall", 4'b1000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        tgl_clr = 1'b1;
        step(1);
        tgl_clr = 1'b0;
        checkOutput("tgl_clr_idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        step(3);

        applyStimulus(4'b0001);
        expectEvent("clean_rise", LAT, 4'b0001, 4'b0000, 4'b0001, 4'b0001);
        step(LAT + 1);
        checkOutput("clean_rise_one_cycle", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0);
        step(3);
        applyStimulus(4'b0000);
        expectEvent("clean_fall", LAT, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        step(LAT + 3);

        applyStimulus(4'b0010);
        step(SC - 1);
        applyStimulus(4'b0000);
        step(LAT + 4);
        checkOutput("glitch_rejected", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

        applyStimulus(4'b0010);
        expectEvent("min_pulse_rise", LAT, 4'b0010, 4'b0000, 4'b0010, 4'b0010);
        step(SC);
        applyStimulus(4'b0000);
        expectEvent("min_pulse_fall", LAT, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
        step(LAT + 3);

        for (int k = 0; k < 10; k++) begin
            applyStimulus((k % 2 == 0) ? 4'b0100 : 4'b0000);
            step(2);
        end
        applyStimulus(4'b0100);
        expectEvent("bounce_rise", LAT, 4'b0100, 4'b0000, 4'b0100, 4'b0100);
        step(LAT + 3);
        checkOutput("bounce_settled", 4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b0);
        applyStimulus(4'b0000);
        expectEvent("bounce_release", LAT, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
        step(LAT + 3);

        tglExp = 4'b1000;
        for (int p = 0; p < 2; p++) begin
            applyStimulus(4'b1000);
            expectEvent("toggle_press", LAT, 4'b1000, 4'b0000, tglExp, 4'b1000);
            step(LAT + 3);
            applyStimulus(4'b0000);
            expectEvent("toggle_release", LAT, 4'b0000, 4'b1000, tglExp, 4'b0000);
            step(LAT + 3);
            tglExp = tglExp ^ 4'b1000;
        end

        applyStimulus(4'b1000);
        expectEvent("clr_beats_rise", LAT, 4'b1000, 4'b0000, 4'b0000, 4'b1000);
        step(LAT - 1);
        tgl_clr = 1'b1;
        step(1);
        tgl_clr = 1'b0;
        step(2);
        applyStimulus(4'b0000);
        expectEvent("clr_release", LAT, 4'b0000, 4'b1000, 4'b0000, 4'b0000);
        step(LAT + 3);

        applyStimulus(4'b0011);
        expectEvent("simul_rise", LAT, 4'b0011, 4'b0000, 4'b0011, 4'b0011);
        step(LAT + 3);
        applyStimulus(4'b0000);
        expectEvent("simul_fall", LAT, 4'b0000, 4'b0011, 4'b0000, 4'b0000);
        step(LAT + 3);

        applyStimulus(4'b0001);
        step(SC);
        reset_n = 1'b0;
        #1;
        checkOutput("mid_reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        reset_n = 1'b1;
        expectEvent("post_reset_rise", LAT, 4'b0001, 4'b0000, 4'b0001, 4'b0001);
        step(LAT + 3);
        applyStimulus(4'b0000);
        expectEvent("post_reset_fall", LAT, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        step(LAT + 3);

        while (sbq.size() > 0) begin
            ev_t e;
            e = sbq.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL %s: event never seen, want cycle=%0d rise=%b fall=%b", e.name, e.cyc, e.rise, e.fall);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
